// File: rtl/univ_sr_pkg.sv
// Mode encodings shared by the universal shift register and its bit cells.
package univ_sr_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHL  = 2'b01;
    localparam mode_t MODE_SHR  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/sr_bit_cell.sv
// One register bit: 4:1 mode mux feeding a synchronous-reset flop.
// With UNIV_SR_QBAR_EN a registered complement flop is added.
module sr_bit_cell
    import univ_sr_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  mode_t mode,
    input  logic  lnb,
    input  logic  rnb,
    input  logic  pin,
`ifdef UNIV_SR_QBAR_EN
    output logic  qbar,
`endif
    output logic  q
);

    logic d;

    // lnb is the next-higher bit, rnb the next-lower bit
    always_comb begin
        d = q;
        case (mode)
            MODE_SHL:  d = rnb;
            MODE_SHR:  d = lnb;
            MODE_LOAD: d = pin;
            default:   d = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

`ifdef UNIV_SR_QBAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            qbar <= 1'b1;
        end else begin
            qbar <= ~d;
        end
    end
`endif

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with serial-frame completion pulse.
// Define UNIV_SR_QBAR_EN to add the registered qbar output.
module univ_shift_reg
    import univ_sr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_t            mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
`ifdef UNIV_SR_QBAR_EN
    output logic [WIDTH-1:0] qbar,
`endif
    output logic             frame_valid
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic lnb;
        logic rnb;

        if (i == WIDTH - 1) begin : g_msb
            assign lnb = sin;
        end else begin : g_hi
            assign lnb = q[i+1];
        end

        if (i == 0) begin : g_lsb
            assign rnb = sin;
        end else begin : g_lo
            assign rnb = q[i-1];
        end

        sr_bit_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .mode (mode),
            .lnb  (lnb),
            .rnb  (rnb),
            .pin  (pin[i]),
`ifdef UNIV_SR_QBAR_EN
            .qbar (qbar[i]),
`endif
            .q    (q[i])
        );
    end

    always_comb begin
        sout = 1'b0;
        case (mode)
            MODE_SHL: sout = q[WIDTH-1];
            MODE_SHR: sout = q[0];
            default:  sout = 1'b0;
        endcase
    end

    // cnt counts shifts in the current frame; a load abandons it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            frame_valid <= 1'b0;
        end else begin
            case (mode)
                MODE_SHL, MODE_SHR: begin
                    if (cnt == LAST) begin
                        cnt         <= '0;
                        frame_valid <= 1'b1;
                    end else begin
                        cnt         <= cnt + 1'b1;
                        frame_valid <= 1'b0;
                    end
                end
                MODE_LOAD: begin
                    cnt         <= '0;
                    frame_valid <= 1'b0;
                end
                default: begin
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=4 and WIDTH=8).
module tb_univ_shift_reg;
    import univ_sr_pkg::*;

    logic       clk;
    logic       rst;
    mode_t      mode4;
    logic       sin4;
    logic [3:0] pin4;
    logic [3:0] q4;
    logic       sout4;
    logic       fv4;
    mode_t      mode8;
    logic       sin8;
    logic [7:0] pin8;
    logic [7:0] q8;
    logic       sout8;
    logic       fv8;
`ifdef UNIV_SR_QBAR_EN
    logic [3:0] qbar4;
    logic [7:0] qbar8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    univ_shift_reg #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode4),
        .sin         (sin4),
        .pin         (pin4),
        .q           (q4),
        .sout        (sout4),
`ifdef UNIV_SR_QBAR_EN
        .qbar        (qbar4),
`endif
        .frame_valid (fv4)
    );

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode8),
        .sin         (sin8),
        .pin         (pin8),
        .q           (q8),
        .sout        (sout8),
`ifdef UNIV_SR_QBAR_EN
        .qbar        (qbar8),
`endif
        .frame_valid (fv8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        mode4 = MODE_HOLD;
        mode8 = MODE_HOLD;
        tick();
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst   = 1'b1;
            mode4 = mode_t'($urandom_range(0, 3));
            mode8 = mode_t'($urandom_range(0, 3));
            sin4  = 1'($urandom);
            sin8  = 1'($urandom);
            pin4  = 4'($urandom);
            pin8  = 8'($urandom);
            tick();
            n_checks++;
            if (q4 !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_q4 edge%0d got %b want 0000", i, q4);
            end
            n_checks++;
            if (fv4 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_fv4 edge%0d got %b want 0", i, fv4);
            end
            n_checks++;
            if (q8 !== 8'h00 || fv8 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_dut8 edge%0d got q=%h fv=%b want 00/0",
                         i, q8, fv8);
            end
`ifdef UNIV_SR_QBAR_EN
            n_checks++;
            if (qbar4 !== 4'b1111) begin
                n_fail++;
                $display("FAIL reset_qbar4 edge%0d got %b want 1111", i, qbar4);
            end
`endif
        end
        rst   = 1'b0;
        mode4 = MODE_HOLD;
        mode8 = MODE_HOLD;
    endtask

    task automatic test_shl();
        logic [3:0] eq [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        logic       sv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        mode4 = MODE_SHL;
        for (int i = 0; i < 4; i++) begin
            sin4 = sv[i];
            tick();
            n_checks++;
            if (q4 !== eq[i] || fv4 !== (i == 3)) begin
                n_fail++;
                $display("FAIL shl_q edge%0d got q=%b fv=%b want q=%b fv=%b",
                         i + 1, q4, fv4, eq[i], (i == 3));
            end
            n_checks++;
            if (sout4 !== eq[i][3]) begin
                n_fail++;
                $display("FAIL shl_sout edge%0d got %b want %b",
                         i + 1, sout4, eq[i][3]);
            end
`ifdef UNIV_SR_QBAR_EN
            n_checks++;
            if (qbar4 !== ~eq[i]) begin
                n_fail++;
                $display("FAIL shl_qbar edge%0d got %b want %b",
                         i + 1, qbar4, ~eq[i]);
            end
`endif
        end
        mode4 = MODE_HOLD;
        #1;
        n_checks++;
        if (sout4 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_sout got %b want 0", sout4);
        end
        tick();
        n_checks++;
        if (q4 !== 4'b1011 || fv4 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_after_frame got q=%b fv=%b want 1011/0",
                     q4, fv4);
        end
    endtask

    task automatic test_shr();
        logic [3:0] eq [4] = '{4'b1000, 4'b1100, 4'b0110, 4'b1011};
        logic       sv [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        mode4 = MODE_SHR;
        for (int i = 0; i < 4; i++) begin
            sin4 = sv[i];
            tick();
            n_checks++;
            if (q4 !== eq[i] || fv4 !== (i == 3)) begin
                n_fail++;
                $display("FAIL shr_q edge%0d got q=%b fv=%b want q=%b fv=%b",
                         i + 1, q4, fv4, eq[i], (i == 3));
            end
            n_checks++;
            if (sout4 !== eq[i][0]) begin
                n_fail++;
                $display("FAIL shr_sout edge%0d got %b want %b",
                         i + 1, sout4, eq[i][0]);
            end
        end
        mode4 = MODE_HOLD;
    endtask

    task automatic test_load_midframe();
        logic [3:0] eq [4] = '{4'b0100, 4'b1000, 4'b0000, 4'b0000};
        do_reset();
        mode4 = MODE_SHL;
        sin4  = 1'b1;
        tick();
        tick();
        mode4 = MODE_LOAD;
        pin4  = 4'b1010;
        #1;
        n_checks++;
        if (sout4 !== 1'b0) begin
            n_fail++;
            $display("FAIL load_sout got %b want 0", sout4);
        end
        tick();
        n_checks++;
        if (q4 !== 4'b1010 || fv4 !== 1'b0) begin
            n_fail++;
            $display("FAIL load_q got q=%b fv=%b want 1010/0", q4, fv4);
        end
        mode4 = MODE_SHL;
        sin4  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (q4 !== eq[i] || fv4 !== (i == 3)) begin
                n_fail++;
                $display("FAIL load_shift edge%0d got q=%b fv=%b want q=%b fv=%b",
                         i + 1, q4, fv4, eq[i], (i == 3));
            end
        end
        mode4 = MODE_HOLD;
    endtask

    task automatic test_hold_reset();
        mode_t seq [7] = '{MODE_SHL, MODE_SHL, MODE_HOLD, MODE_HOLD,
                           MODE_HOLD, MODE_SHR, MODE_SHL};
        do_reset();
        sin4 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            mode4 = seq[i];
            tick();
            n_checks++;
            if (fv4 !== (i == 6)) begin
                n_fail++;
                $display("FAIL hold_pause edge%0d got fv=%b want %b",
                         i + 1, fv4, (i == 6));
            end
        end
        do_reset();
        mode4 = MODE_SHL;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (q4 !== 4'b0000 || fv4 !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_rst got q=%b fv=%b want 0000/0", q4, fv4);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (fv4 !== (i == 3)) begin
                n_fail++;
                $display("FAIL rst_restart edge%0d got fv=%b want %b",
                         i + 1, fv4, (i == 3));
            end
        end
        mode4 = MODE_HOLD;
    endtask

    task automatic test_back_to_back();
        logic [7:0] eq8;
        do_reset();
        eq8   = 8'h00;
        mode8 = MODE_SHL;
        for (int i = 1; i <= 24; i++) begin
            sin8 = 1'(i % 3 == 0);
            eq8  = {eq8[6:0], sin8};
            tick();
            n_checks++;
            if (q8 !== eq8 || fv8 !== (i % 8 == 0)) begin
                n_fail++;
                $display("FAIL b2b_w8 edge%0d got q=%h fv=%b want q=%h fv=%b",
                         i, q8, fv8, eq8, (i % 8 == 0));
            end
        end
        mode8 = MODE_HOLD;
    endtask

    initial begin
        rst   = 1'b0;
        mode4 = MODE_HOLD;
        mode8 = MODE_HOLD;
        sin4  = 1'b0;
        sin8  = 1'b0;
        pin4  = '0;
        pin8  = '0;
        test_reset();
        test_shl();
        test_shr();
        test_load_midframe();
        test_hold_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
